// File: rtl/sdm_pkg.sv
// Shared types and constants for the PDM modulator: FSM states, default widths,
// dither LFSR seed/taps and the integrator saturation helper.
package sdm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sdm_state_t;

  localparam int ACC_W_DEF = 24;
  localparam int LIMIT_DEF = 26214;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form over bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Symmetric clamp to +/-(2^(w-1)-1); callers keep w <= 30 so sums never wrap.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
    logic signed [31:0] lim;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/sdm_lfsr.sv
// Dither source: 16-bit LFSR, one step per asserted advance, exposes its two LSBs.
// Zero latency to the output; no backpressure.
module sdm_lfsr
  import sdm_pkg::*;
(
  input  logic       clk_out,
  input  logic       reset_n,
  input  logic       advance,
  output logic [1:0] lsbs
);

  logic [15:0] lfsr;

  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n)
      lfsr <= LFSR_SEED;
    else if (advance)
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign lsbs = lfsr[1:0];

endmodule

// File: rtl/sdm_pdm_modulator.sv
// 2nd-order sigma-delta to 1-bit PDM; each sample drives OSR updates, first bit 1 clk after load.
// One-entry input buffer (in_ready = !full); define SDM_DITHER_EN to add LFSR dither to x.
module sdm_pdm_modulator
  import sdm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OSR        = 4,
  parameter int LIMIT      = LIMIT_DEF
) (
  input  logic                         clk_out,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         pdm_out,
  output logic                         busy,
  output logic                         underrun
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic signed [31:0] FB_MAG = 32'sd1 <<< (DATA_WIDTH - 1);

  sdm_state_t                   state;
  logic                         armed;
  logic [CNT_W-1:0]             phase;
  logic                         buf_full;
  logic signed [DATA_WIDTH-1:0] buf_dat;
  logic signed [DATA_WIDTH-1:0] act_dat;
  logic signed [ACC_W-1:0]      i1;
  logic signed [ACC_W-1:0]      i2;

  logic signed [DATA_WIDTH-1:0] clamped;
  logic signed [31:0]           dither;
  logic signed [31:0]           x;
  logic signed [31:0]           fb;
  logic signed [31:0]           i1_next;
  logic signed [31:0]           i2_next;
  logic                         xfer;
  logic                         wrap;

  always_comb begin
    clamped = in_data;
    if (int'(in_data) > LIMIT)
      clamped = DATA_WIDTH'(LIMIT);
    else if (int'(in_data) < -LIMIT)
      clamped = DATA_WIDTH'(-LIMIT);
  end

`ifdef SDM_DITHER_EN
  logic [1:0] dither_lsbs;

  sdm_lfsr u_lfsr (
    .clk_out (clk_out),
    .reset_n (reset_n),
    .advance (armed && enable && (state == RUN)),
    .lsbs    (dither_lsbs)
  );

  assign dither = 32'(signed'(dither_lsbs));
`else
  assign dither = '0;
`endif

  // i2 integrates the freshly updated i1 so the noise transfer is (1 - z^-1)^2.
  assign x       = 32'(act_dat) + dither;
  assign fb      = pdm_out ? FB_MAG : -FB_MAG;
  assign i1_next = sat(32'(i1) + x - fb, ACC_W);
  assign i2_next = sat(32'(i2) + i1_next - fb, ACC_W);

  assign xfer = in_valid && in_ready;
  assign wrap = (phase == CNT_LAST);

  // armed holds off the first edge after reset release so state moves on the second.
  always_ff @(posedge clk_out or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      phase    <= '0;
      buf_full <= 1'b0;
      buf_dat  <= '0;
      act_dat  <= '0;
      i1       <= '0;
      i2       <= '0;
      pdm_out  <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else if (!enable) begin
      state    <= IDLE;
      phase    <= '0;
      buf_full <= 1'b0;
      i1       <= '0;
      i2       <= '0;
      underrun <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      pdm_out  <= ~pdm_out;
    end else begin
      case (state)
        IDLE: begin
          state    <= PRIME;
          pdm_out  <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        PRIME: begin
          if (xfer) begin
            state   <= RUN;
            act_dat <= clamped;
            phase   <= '0;
          end
        end
        RUN: begin
          i1      <= ACC_W'(i1_next);
          i2      <= ACC_W'(i2_next);
          pdm_out <= !i2_next[31];
          if (wrap) begin
            phase <= '0;
            if (buf_full)
              act_dat <= buf_dat;
            else
              underrun <= 1'b1;
          end else begin
            phase <= phase + CNT_W'(1);
          end
          if (xfer) begin
            buf_dat  <= clamped;
            buf_full <= 1'b1;
            in_ready <= 1'b0;
          end else if (wrap && buf_full) begin
            buf_full <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdm_pdm_modulator.sv
// Bench for sdm_pdm_modulator: accepted samples go to a scoreboard queue, a reference
// loop pops them per OSR period and predicts every PDM bit plus the handshake/underrun flags.
module tb_sdm_pdm_modulator;

  localparam int OSR     = 4;
  localparam int LIMIT   = 26214;
  localparam int ACC_MAX = 8388607;

  logic               clk_out = 1'b0;
  logic               reset_n = 1'b1;
  logic               enable;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready;
  logic               pdm_out;
  logic               busy;
  logic               underrun;

  int n_checks = 0;
  int n_errors = 0;

  int sampq[$];
  bit m_run, m_pdm, m_und;
  int m_cur, m_ph, m_i1, m_i2;
  int ones, nbits, cnt_lim;

  sdm_pdm_modulator #(
    .DATA_WIDTH (16),
    .ACC_W      (24),
    .OSR        (OSR),
    .LIMIT      (LIMIT)
  ) dut (
    .clk_out  (clk_out),
    .reset_n  (reset_n),
    .enable   (enable),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pdm_out  (pdm_out),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk_out = ~clk_out;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp, input int tol = 0);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, got, exp, tol, $time);
    end
  endtask

  function automatic int clampv(input int v);
    if (v > LIMIT) return LIMIT;
    if (v < -LIMIT) return -LIMIT;
    return v;
  endfunction

  function automatic int satv(input int v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < -ACC_MAX) return -ACC_MAX;
    return v;
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_und = 1'b0;
    m_i1  = 0;
    m_i2  = 0;
    m_ph  = 0;
    sampq.delete();
  endtask

  // One clock: note the handshake, advance the reference, then compare all outputs.
  task automatic step(output bit xfer);
    bit en_b;
    int s;
    int fb;
    en_b = enable;
    xfer = en_b && in_valid && in_ready;
    s    = clampv(int'(in_data));
    @(posedge clk_out);
    #1;
    if (!en_b) begin
      model_reset();
      m_pdm = !m_pdm;
    end else if (m_run) begin
      fb    = m_pdm ? 32768 : -32768;
      m_i1  = satv(m_i1 + m_cur - fb);
      m_i2  = satv(m_i2 + m_i1 - fb);
      m_pdm = (m_i2 >= 0);
      if (nbits < cnt_lim) begin
        ones += int'(pdm_out);
        nbits++;
      end
      m_ph++;
      if (m_ph == OSR) begin
        m_ph = 0;
        if (sampq.size() > 0) m_cur = sampq.pop_front();
        else m_und = 1'b1;
      end
      if (xfer) sampq.push_back(s);
    end else begin
      m_pdm = 1'b0;
      if (xfer) begin
        m_run = 1'b1;
        m_cur = s;
        m_ph  = 0;
      end
    end
    check("pdm", int'(pdm_out), int'(m_pdm));
    check("busy", int'(busy), int'(en_b));
    check("in_ready", int'(in_ready), int'(en_b && (sampq.size() == 0)));
    check("underrun", int'(underrun), int'(m_und));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_pdm", int'(pdm_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_underrun", int'(underrun), 0);
    model_reset();
    m_pdm = 1'b0;
    @(posedge clk_out);
    #1;
    reset_n = 1'b1;
    @(posedge clk_out);
    #1;
    check("rel_hold_pdm", int'(pdm_out), 0);
    check("rel_hold_busy", int'(busy), 0);
  endtask

  function automatic logic signed [15:0] pick(input int mode, input int val);
    if (mode == 0) return 16'(val);
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic run_seg(input string tag, input int mode, input int val, input int nb,
                         input int exp_ones, input int tol);
    bit x;
    int budget;
    ones     = 0;
    nbits    = 0;
    cnt_lim  = nb;
    budget   = 2 * nb + 40;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = pick(mode, val);
    while (nbits < nb && budget > 0) begin
      step(x);
      budget--;
      if (x) in_data = pick(mode, val);
    end
    check({tag, "_bits"}, nbits, nb);
    if (exp_ones >= 0) check({tag, "_ones"}, ones, exp_ones, tol);
    enable   = 1'b0;
    in_valid = 1'b0;
    step(x);
    cnt_lim = 0;
  endtask

  initial begin
    bit x;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    cnt_lim  = 0;
    m_pdm    = 1'b0;

    do_reset();
    repeat (7) step(x);

    run_seg("zero", 0, 0, 256, 128, 1);
    run_seg("half", 0, 16384, 1024, 768, 4);
    run_seg("clamp_pos", 0, 32767, 1024, 922, 5);
    run_seg("clamp_neg", 0, -32768, 256, 26, 4);
    run_seg("rand", 1, 0, 150, -1, 0);
    repeat (3) step(x);

    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'sd8000;
    repeat (30) step(x);
    in_valid = 1'b0;
    repeat (8) step(x);
    check("und_set", int'(underrun), 1);
    in_valid = 1'b1;
    repeat (20) step(x);
    check("und_sticky", int'(underrun), 1);
    enable = 1'b0;
    step(x);
    check("und_clear", int'(underrun), 0);
    in_valid = 1'b0;
    repeat (2) step(x);

    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = -16'sd12000;
    repeat (13) step(x);
    do_reset();
    repeat (2) step(x);
    run_seg("post_rst", 0, -5000, 64, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
